// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin share of one UART transmitter between N_REQ byte requesters.
// Latency : req in IDLE at cycle T -> gnt/tx_start at T+1; done pulse at T+FRAME_LEN+2.
// Backpressure: req is a level, sampled only in IDLE; losers simply keep req high.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   req, req_data     per-requester request level and byte (requester i at [i*DATA_W +: DATA_W])
//   gnt               one-hot grant, high for the whole frame
//   done              one-cycle pulse on the granted bit after an error-free frame
//   tx_start, tx_data transmitter enable and latched byte
//   tx_busy           transmitter busy status
//   err, err_clr      sticky protocol error and its synchronous clear
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 11,
  parameter int GAP_LEN   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (FRAME_LEN > GAP_LEN) ? FRAME_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The IDLE arbitration cycle is itself the last low cycle of the guard gap,
  // so the GAP state only covers GAP_LEN-1 cycles. With GAP_LEN=1 the GAP
  // state is skipped entirely and done pulses in the IDLE cycle instead.
  localparam int GAP_LAST_I = (GAP_LEN > 1) ? GAP_LEN - 2 : 0;

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LAST_I);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   N_REQ_EXT  = (PTR_W+1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   cur;       // index of the requester owning the current frame

  logic               any_req;
  logic [PTR_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;
  logic [PTR_W:0]     cand;
  logic               busy_fail;
  logic [PTR_W-1:0]   cur_next;
  state_t             after_frame;

  // Round-robin search starting at ptr. Walking the offsets from highest to
  // lowest lets the nearest asserted requester overwrite any farther one.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= N_REQ_EXT) begin
        cand = cand - N_REQ_EXT;
      end
      if (req[cand[PTR_W-1:0]]) begin
        any_req = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // cnt=0 is the cycle the transmitter first sees tx_start, so it may still
  // be idle there; from cnt=1 through the STOP cycle it must report busy.
  assign busy_fail   = (cnt != '0) && !tx_busy;
  assign cur_next    = (cur == PTR_LAST) ? '0 : cur + 1'b1;
  assign after_frame = (GAP_LEN > 1) ? S_GAP : S_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      cur      <= '0;
      gnt      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      err      <= 1'b0;
    end else begin
      done <= '0;
      // A busy-check failure later in this block overrides the clear.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (any_req) begin
            state    <= S_SEND;
            cnt      <= '0;
            cur      <= win_idx;
            gnt      <= ONE_HOT0 << win_idx;
            tx_data  <= win_data;
            tx_start <= 1'b1;
          end
        end

        S_SEND: begin
          if (busy_fail) begin
            // Abort: release the transmitter, skip done, but still move
            // the pointer so a broken requester cannot monopolise the line.
            err      <= 1'b1;
            tx_start <= 1'b0;
            gnt      <= '0;
            tx_data  <= '0;
            ptr      <= cur_next;
            cnt      <= '0;
            state    <= after_frame;
          end else if (cnt == FRAME_LAST) begin
            tx_start <= 1'b0;
            gnt      <= '0;
            done     <= ONE_HOT0 << cur;
            ptr      <= cur_next;
            cnt      <= '0;
            state    <= after_frame;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : scoreboard bench for uart_tx_arbiter with a simple transmitter model.
// Latency : expected events carry absolute cycle numbers; a negedge monitor pops them.
// Backpressure: not applicable; the transmitter model answers tx_start with tx_busy.
module tb_uart_tx_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 11;
  localparam int GAP_LEN   = 2;

  localparam int EV_GNT  = 0;
  localparam int EV_LEN  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy = 1'b0;
  logic                    err;
  logic                    err_clr = 1'b0;

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int        kind;
    int        cyc;
    logic [7:0] val;
    logic [7:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Transmitter model: idle in the first tx_start cycle, then busy for
  // FRAME_LEN cycles; busy_en=0 models a transmitter that never starts.
  logic busy_en = 1'b1;
  int   m = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        tx_busy = busy_en && (m >= 1) && (m <= FRAME_LEN);
        m = m + 1;
      end else begin
        tx_busy = 1'b0;
        m = 0;
      end
    end
  end

  function automatic logic [7:0] byte_of(input int idx);
    return req_data[idx*DATA_W +: DATA_W];
  endfunction

  task automatic push(input int kind, input int c, input logic [7:0] val, input logic [7:0] dat);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  // Normal frame for a request presented in IDLE cycle c.
  task automatic frame_exp(input int c, input int idx);
    push(EV_GNT,  c + 1,  8'(1 << idx), byte_of(idx));
    push(EV_LEN,  c + 13, 8'd12, 8'h00);
    push(EV_DONE, c + 13, 8'(1 << idx), 8'h00);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them in order.
  logic [7:0]       hold_data = '0;
  logic [N_REQ-1:0] prev_gnt = '0;
  logic             prev_start = 1'b0;
  logic             prev_err = 1'b0;
  int               run_len = 0;

  task automatic emit(input int kind, input logic [7:0] val, input logic [7:0] dat);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d val=%h dat=%h, expected no event",
               kind, cyc, val, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == EV_GNT) hold_data = e.dat;
      if (e.kind != kind || e.cyc != cyc || e.val !== val ||
          (kind == EV_GNT && e.dat !== dat)) begin
        n_bad++;
        $display("FAIL event_order: got kind=%0d cyc=%0d val=%h dat=%h, expected kind=%0d cyc=%0d val=%h dat=%h",
                 kind, cyc, val, dat, e.kind, e.cyc, e.val, e.dat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (gnt != '0 && prev_gnt == '0) emit(EV_GNT, 8'(gnt), tx_data);
    if (!tx_start && prev_start)     emit(EV_LEN, 8'(run_len), 8'h00);
    if (done != '0)                  emit(EV_DONE, 8'(done), 8'h00);
    if (err !== prev_err)            emit(EV_ERR, 8'(err), 8'h00);
    if (tx_start) chk("tx_data_hold", 32'(tx_data), 32'(hold_data));
    run_len    = tx_start ? run_len + 1 : 0;
    prev_gnt   = gnt;
    prev_start = tx_start;
    prev_err   = err;
  end

  initial begin
    req_data = {8'h3C, 8'h96, 8'h5A, 8'hA5};

    // Reset state
    wait_cyc(1);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_gnt",      32'(gnt),      32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    wait_cyc(2);
    rst = 1'b0;

    // Single request from requester 0
    wait_cyc(3);
    frame_exp(3, 0);
    req = 4'b0001;
    wait_cyc(4);
    req = 4'b0000;

    // Reset while idle so the pointer starts from 0 again
    wait_cyc(20);
    rst = 1'b1;
    wait_cyc(21);
    rst = 1'b0;

    // All requesters continuously requesting: 0,1,2,3,0 every 14 cycles
    wait_cyc(24);
    for (int k = 0; k < 5; k++) frame_exp(24 + 14 * k, k % 4);
    req = 4'b1111;
    wait_cyc(82);
    req = 4'b0000;

    // Grant to 2, then 0011 wraps past 3 to 0, then 1
    wait_cyc(100);
    frame_exp(100, 2);
    req = 4'b0100;
    wait_cyc(102);
    frame_exp(114, 0);
    frame_exp(128, 1);
    req = 4'b0011;
    wait_cyc(130);
    req = 4'b0000;

    // Transmitter never goes busy: abort, err, pointer still advances
    wait_cyc(145);
    busy_en = 1'b0;
    wait_cyc(146);
    push(EV_GNT, 147, 8'b1000, byte_of(3));
    push(EV_LEN, 149, 8'd2, 8'h00);
    push(EV_ERR, 149, 8'd1, 8'h00);
    req = 4'b1000;
    wait_cyc(148);
    req = 4'b0000;
    wait_cyc(153);
    push(EV_ERR, 154, 8'd0, 8'h00);
    err_clr = 1'b1;
    wait_cyc(154);
    err_clr = 1'b0;
    wait_cyc(155);
    busy_en = 1'b1;
    wait_cyc(156);
    frame_exp(156, 0);
    req = 4'b1001;
    wait_cyc(158);
    req = 4'b0000;

    // Reset mid-frame at cnt=5, then requester 1 on the first IDLE edge
    wait_cyc(172);
    push(EV_GNT, 173, 8'b0100, byte_of(2));
    req = 4'b0100;
    wait_cyc(174);
    req = 4'b0000;
    wait_cyc(178);
    push(EV_LEN, 178, 8'd5, 8'h00);
    frame_exp(180, 1);
    rst = 1'b1;
    req = 4'b0010;
    #1;
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_gnt",      32'(gnt),      32'd0);
    chk("midrst_tx_data",  32'(tx_data),  32'd0);
    chk("midrst_done",     32'(done),     32'd0);
    wait_cyc(180);
    rst = 1'b0;
    wait_cyc(182);
    req = 4'b0000;

    // Request withdrawn at cnt=3: frame completes, no re-grant
    wait_cyc(196);
    frame_exp(196, 0);
    req = 4'b0001;
    wait_cyc(200);
    req = 4'b0000;

    wait_cyc(240);
    chk("events_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter (start/data/parity/stop FSM with `tx_start`/`tx_busy`) between `N_REQ` byte requesters using round-robin arbitration. It latches the winning byte, holds `tx_start` high for exactly one frame, and then drops it for a guard gap so the transmitter returns to IDLE. It also flags a transmitter that fails to go busy or drops busy mid-frame. It sits between the host-side producers and the transmitter's control and data inputs.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `FRAME_LEN`, default 11: transmitter busy cycles per frame (1 start + 8 data + 1 parity + 1 stop).
- `GAP_LEN`, default 2: cycles `tx_start` is held low between frames, minimum 1.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `N_REQ`: per-requester transmit request, level.
- `req_data` in `N_REQ*DATA_W`: byte of requester i in bits `[i*DATA_W +: DATA_W]`.
- `gnt` out `N_REQ`: one-hot, high for the whole frame of the granted requester.
- `done` out `N_REQ`: one-cycle pulse on the granted bit when its frame completed without error.
- `tx_start` out 1: transmitter enable, held high for the frame.
- `tx_data` out `DATA_W`: latched byte, stable while `tx_start` is high.
- `tx_busy` in 1: transmitter busy status.
- `err` out 1: sticky protocol error.
- `err_clr` in 1: synchronous clear of `err`.

## Operation
- States are IDLE, SEND and GAP. A frame counter `cnt` (4 bits at the defaults, sized to hold `FRAME_LEN`) and a round-robin pointer `ptr` (log2 `N_REQ` bits) are registered.
- **IDLE**
  - `tx_start`=0 and `gnt`=0.
  - If any `req` bit is high, the winner is the first asserted index searching from `ptr` upward, with wrap.
  - On the next edge: `gnt` is set to the winner's one-hot, `tx_data` is loaded with the winner's byte, `tx_start` goes to 1, `cnt` goes to 0, and the state moves to SEND.
- **SEND**
  - `tx_start`=1 and `cnt` increments each cycle.
  - Busy check at `cnt`=1: `tx_busy` must be 1.
  - For `cnt`=1..`FRAME_LEN`, `tx_busy` must stay 1.
  - A violation of either check sets `err` and aborts. On the abort edge `tx_start`, `gnt` and `tx_data` go to 0, no `done` pulse is issued, `ptr` advances, and the state moves to GAP.
  - Normal exit happens on the edge after the `cnt`=`FRAME_LEN` cycle (the transmitter's STOP cycle). On that edge `tx_start` goes to 0, `gnt` goes to 0, `done[winner]` goes to 1, `ptr` becomes winner+1 mod `N_REQ`, and the state moves to GAP.
- **GAP**
  - `tx_start`=0 for `GAP_LEN` cycles, then the state returns to IDLE.
  - `done` is high only in the first GAP cycle.
- **Request handling**
  - `req` is sampled only in IDLE. Deasserting `req` during SEND or GAP does not affect the current frame.
  - A `req` still high when the block returns to IDLE is treated as a new request.
  - `req_data` only needs to be valid in the IDLE cycle that grants it.
- **Error flag**
  - `err` is set by either busy-check failure.
  - `err_clr` clears it. If a set and `err_clr` occur in the same cycle, the set wins.

## Timing
- Reset value of every output is 0; `ptr` resets to 0 and the state resets to IDLE.
- Reset asserted mid-frame clears all outputs asynchronously. The transmitter sees `tx_start`=0 and returns to IDLE. No `done` pulse is issued.
- Grant latency: `req` high in IDLE at cycle T gives `gnt` and `tx_start` high at T+1.
- `tx_start` stays high for `FRAME_LEN`+1 cycles (T+1..T+12 at the defaults). `done` pulses at T+13.
- The earliest next grant is at T+13+`GAP_LEN`. Frame-to-frame period at the defaults is 14 cycles.
- When several requests arrive in the same cycle, exactly one is granted, chosen by `ptr`. The search wraps from index `N_REQ`-1 to 0.
- `tx_busy` may be 0 at `cnt`=0 (the transmitter is still in IDLE); this is not an error.

## Test plan
- **Single request.** `req`=0001, `req_data[7:0]`=0xA5, transmitter model busy for 11 cycles. Required: `gnt`=0001 and `tx_data`=0xA5 one cycle after `req`; `tx_start` high for 12 cycles; `done`=0001 pulse for one cycle; `err`=0.
- **All requesters continuously requesting.** `req`=1111 held, `ptr` starts at 0. Required: grant order 0,1,2,3,0 with exactly 14 cycles between grants.
- **Wrap and skip.** After a grant to requester 2, `req`=0011. Required: the next grant goes to 0 (the search wraps past 3 and finds 0).
- **Transmitter never goes busy.** Hold `tx_busy`=0. Required: `err`=1 at `cnt`=2, `tx_start` drops, no `done` pulse, `ptr` advances. A subsequent `err_clr` pulse returns `err` to 0.
- **Reset mid-frame.** Assert `rst` at `cnt`=5. Required: `tx_start`, `gnt`, `tx_data` and `done` are 0 immediately. After release with `req`=0010, requester 1 is granted on the first IDLE edge.
- **Request withdrawn mid-frame.** Drop `req` at `cnt`=3. Required: the frame still completes with `done` pulsed and no re-grant.
